ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 32-bit pipeline, directly upstream of the memory stage. It computes the ALU result, zero flag and branch target, and registers them with the memory and write-back control into the EX/MEM pipeline register that feeds the memory stage. MUL is an iterative shift-add operation. While a multiply runs, the stage stalls upstream and inserts bubbles downstream. A flush input squashes the in-flight instruction when a branch is taken.

Parameters:
MUL_STEP_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; multiply iterations N = 32/MUL_STEP_BITS.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  branch-taken squash from the memory stage (PCSrc)
ex_valid  input  1  instruction present in EX
ex_alu_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MUL (low 32 bits); other codes give result 0
ex_alu_src  input  1  0: operand B = rt_data; 1: operand B = imm
ex_mem_br  input  1  branch instruction
ex_mem_write  input  1  store
ex_mem_read  input  1  load
ex_wb  input  2  write-back control, passed through
rs_data  input  32  operand A
rt_data  input  32  register operand B and store data
imm  input  32  sign-extended immediate
pc_plus4  input  32  PC+4 of this instruction
rt_addr  input  5  rt field
rd_addr  input  5  rd field
reg_dst  input  1  0: dest = rt_addr; 1: dest = rd_addr
ex_busy  output  1  multiply in progress; upstream must hold EX inputs
Mem_Br  output  1  registered branch flag
Zero  output  1  registered (result == 0)
write_En  output  1  registered store enable
read_En  output  1  registered load enable
DataAddress  output  32  registered ALU result
WriteData  output  32  registered rt_data
Mem_WB  output  2  registered write-back control
dest  output  5  registered destination register
branch_target  output  32  registered pc_plus4 + (imm << 2), mod 2^32

Behaviour:
- Reset: all registered outputs are 0, ex_busy = 0, multiplier state is cleared, and any multiply in progress is aborted.
- Bubble: all EX/MEM outputs load 0.
- Priority, highest first: rst, then flush, then busy completion, then new issue.
- Flush: the EX/MEM register loads a bubble, any running multiply is aborted, and ex_busy is 0 on the next cycle.
- Single-cycle ops (not MUL, ex_valid=1, not busy): the EX/MEM register loads the result on the next edge, so latency is 1 cycle.
- ex_valid=0 and not busy: the EX/MEM register loads a bubble.
- Arithmetic wraps mod 2^32. SUB is A - B. SLT yields 1 if $signed(A) < $signed(B), else 0.
- Zero is computed on the final result; this includes MUL.
- MUL state machine, states IDLE and RUN:
  - IDLE→RUN when ex_valid=1 and op=MUL with no flush. The stage captures A, B, all control, dest and branch_target, clears the accumulator, sets count=0, and ex_busy goes 1 next cycle. The EX/MEM register loads a bubble on the issue edge.
  - RUN: each cycle adds the multiplicand shifted by MUL_STEP_BITS, indexed by the low MUL_STEP_BITS bits of the multiplier, then shifts and increments count.
  - While in RUN, the EX/MEM register loads bubbles and EX inputs are ignored.
  - RUN→IDLE on the edge where count == N-1. The EX/MEM register loads the low 32 bits of the product with the captured control, and ex_busy drops together with it.
  - Issue-to-output latency is N+1 edges. ex_busy is high for exactly N cycles.
  - A new instruction presented in the cycle after ex_busy falls is accepted normally.

Optional Feature:
EX_MUL_EN
- Defined: iterative multiplier, ex_busy and the RUN state exist as described above.
- Undefined: the multiplier logic is removed, ex_busy is tied to 0, and op 011 behaves as an unknown code (single-cycle, result 0, Zero=1).

Test Plan:
- rst=1 for 2 cycles, then rst=0 with ex_valid=0 -> all outputs 0 and ex_busy=0.
- ADD rs=0x7FFFFFFF, imm=1, alu_src=1, reg_dst=0, rt_addr=5 -> next cycle DataAddress=0x80000000, Zero=0, dest=5.
- SUB rs=rt=0x1234, mem_br=1, pc_plus4=0x100, imm=0xFFFFFFFF -> Mem_Br=1, Zero=1, branch_target=0xFC.
- SLT rs=0xFFFFFFFF, rt=1 -> DataAddress=1; then SW with rt=0xDEADBEEF, imm=8, rs=0x40 -> write_En=1, DataAddress=0x48, WriteData=0xDEADBEEF.
- MUL 0xFFFF x 0x10001, wb=2'b11, MUL_STEP_BITS=1 -> ex_busy high 32 cycles with all-zero outputs; then DataAddress=0xFFFFFFFF, Mem_WB=3, one cycle after ex_busy rose + 32; repeat with MUL_STEP_BITS=4 -> busy for 8 cycles.
- MUL issued, flush pulsed 5 cycles in -> ex_busy=0 next cycle, outputs stay bubble, no product ever appears; an ADD issued afterwards completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: EX-stage instruction inputs and EX/MEM pipeline register outputs.
// The slave side is the execute stage; the master side is the upstream/downstream pipeline.
interface ex_stage_if;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned WB_W  = 2;
   localparam int unsigned OP_W  = 3;

   // Instruction presented to EX
   logic             flush;
   logic             ex_valid;
   logic [OP_W-1:0]  ex_alu_op;
   logic             ex_alu_src;
   logic             ex_mem_br;
   logic             ex_mem_write;
   logic             ex_mem_read;
   logic [WB_W-1:0]  ex_wb;
   logic [XLEN-1:0]  rs_data;
   logic [XLEN-1:0]  rt_data;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  pc_plus4;
   logic [REG_W-1:0] rt_addr;
   logic [REG_W-1:0] rd_addr;
   logic             reg_dst;

   // Stall back to upstream and EX/MEM register contents
   logic             ex_busy;
   logic             Mem_Br;
   logic             Zero;
   logic             write_En;
   logic             read_En;
   logic [XLEN-1:0]  DataAddress;
   logic [XLEN-1:0]  WriteData;
   logic [WB_W-1:0]  Mem_WB;
   logic [REG_W-1:0] dest;
   logic [XLEN-1:0]  branch_target;

   modport master (
      output flush, ex_valid, ex_alu_op, ex_alu_src, ex_mem_br, ex_mem_write, ex_mem_read,
             ex_wb, rs_data, rt_data, imm, pc_plus4, rt_addr, rd_addr, reg_dst,
      input  ex_busy, Mem_Br, Zero, write_En, read_En, DataAddress, WriteData, Mem_WB,
             dest, branch_target
   );

   modport slave (
      input  flush, ex_valid, ex_alu_op, ex_alu_src, ex_mem_br, ex_mem_write, ex_mem_read,
             ex_wb, rs_data, rt_data, imm, pc_plus4, rt_addr, rd_addr, reg_dst,
      output ex_busy, Mem_Br, Zero, write_En, read_En, DataAddress, WriteData, Mem_WB,
             dest, branch_target
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage feeding the EX/MEM pipeline register.
// Single-cycle ALU ops (AND/OR/ADD/SUB/SLT) plus branch target generation.
// Optional macro EX_MUL_EN adds an iterative shift-add multiplier (op 011) that
// retires MUL_STEP_BITS multiplier bits per cycle and stalls upstream via ex_busy.
// Without EX_MUL_EN, op 011 is an unknown code (result 0) and ex_busy is tied low.
module ex_stage #(
   parameter int unsigned MUL_STEP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   ex_stage_if.slave  bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned WB_W  = 2;
   localparam int unsigned OP_W  = 3;

   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_OR  = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_MUL = 3'b011;
   localparam logic [OP_W-1:0] OP_SUB = 3'b110;
   localparam logic [OP_W-1:0] OP_SLT = 3'b111;

   typedef struct packed {
      logic             mem_br;
      logic             zero;
      logic             write_en;
      logic             read_en;
      logic [XLEN-1:0]  data_address;
      logic [XLEN-1:0]  write_data;
      logic [WB_W-1:0]  mem_wb;
      logic [REG_W-1:0] dest;
      logic [XLEN-1:0]  branch_target;
   } exmem_t;

   if (!(MUL_STEP_BITS == 1 || MUL_STEP_BITS == 2 || MUL_STEP_BITS == 4)) begin : g_bad_step
      $error("ex_stage: MUL_STEP_BITS must be 1, 2 or 4");
   end

   logic [XLEN-1:0] op_b_c;
   logic [XLEN-1:0] alu_res_c;
   exmem_t          issue_c;
   exmem_t          exmem_d;
   exmem_t          exmem_q;

   // Operand B select and single-cycle ALU
   always_comb begin
      op_b_c    = bus.ex_alu_src ? bus.imm : bus.rt_data;
      alu_res_c = '0;
      case (bus.ex_alu_op)
         OP_AND:  alu_res_c = bus.rs_data & op_b_c;
         OP_OR:   alu_res_c = bus.rs_data | op_b_c;
         OP_ADD:  alu_res_c = bus.rs_data + op_b_c;
         OP_SUB:  alu_res_c = bus.rs_data - op_b_c;
         OP_SLT:  alu_res_c = XLEN'($signed(bus.rs_data) < $signed(op_b_c));
         // multiply result, when present, comes from the iterative unit
         OP_MUL:  alu_res_c = '0;
         default: alu_res_c = '0;
      endcase
   end

   // EX/MEM payload for the instruction currently in EX
   always_comb begin
      issue_c               = '0;
      issue_c.mem_br        = bus.ex_mem_br;
      issue_c.zero          = (alu_res_c == '0);
      issue_c.write_en      = bus.ex_mem_write;
      issue_c.read_en       = bus.ex_mem_read;
      issue_c.data_address  = alu_res_c;
      issue_c.write_data    = bus.rt_data;
      issue_c.mem_wb        = bus.ex_wb;
      issue_c.dest          = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
      issue_c.branch_target = bus.pc_plus4 + (bus.imm << 2);
   end

`ifdef EX_MUL_EN
   localparam int unsigned MUL_ITERS = XLEN / MUL_STEP_BITS;
   localparam int unsigned CNT_W     = $clog2(MUL_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state_q;
   state_t          state_d;
   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] acc_q;
   logic [CNT_W-1:0] count_q;
   exmem_t          cap_q;
   logic [XLEN-1:0] partial_c;
   logic [XLEN-1:0] product_c;
   logic            issue_mul_c;

   assign issue_mul_c = (state_q == S_IDLE) && bus.ex_valid && !bus.flush &&
                        (bus.ex_alu_op == OP_MUL);

   // Partial product for the low MUL_STEP_BITS multiplier bits
   always_comb begin
      partial_c = '0;
      for (int unsigned i = 0; i < MUL_STEP_BITS; i++) begin
         if (mplier_q[5'(i)]) partial_c = partial_c + (mcand_q << i);
      end
      product_c = acc_q + partial_c;
   end

   // Multiplier FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Multiplier FSM next state; flush aborts a running multiply
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (issue_mul_c) state_d = S_RUN;
         S_RUN:   if (bus.flush || count_q == CNT_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // EX/MEM next value: bubble unless a single-cycle op issues or a multiply completes
   always_comb begin
      exmem_d = '0;
      if (bus.flush) begin
         exmem_d = '0;
      end else if (state_q == S_RUN) begin
         if (count_q == CNT_LAST) begin
            exmem_d              = cap_q;
            exmem_d.data_address = product_c;
            exmem_d.zero         = (product_c == '0);
         end
      end else if (bus.ex_valid && bus.ex_alu_op != OP_MUL) begin
         exmem_d = issue_c;
      end
   end

   // Multiplier datapath: capture on issue, shift-add while running
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         cap_q    <= '0;
      end else if (issue_mul_c) begin
         mcand_q  <= bus.rs_data;
         mplier_q <= op_b_c;
         acc_q    <= '0;
         count_q  <= '0;
         cap_q    <= issue_c;
      end else if (state_q == S_RUN) begin
         acc_q    <= product_c;
         mcand_q  <= mcand_q << MUL_STEP_BITS;
         mplier_q <= mplier_q >> MUL_STEP_BITS;
         count_q  <= count_q + CNT_W'(1);
      end
   end

   assign bus.ex_busy = (state_q == S_RUN);
`else
   // EX/MEM next value: bubble unless an instruction issues without flush
   always_comb begin
      exmem_d = '0;
      if (!bus.flush && bus.ex_valid) exmem_d = issue_c;
   end

   assign bus.ex_busy = 1'b0;
`endif

   // EX/MEM pipeline register
   always_ff @(posedge clk) begin
      if (rst) exmem_q <= '0;
      else     exmem_q <= exmem_d;
   end

   assign bus.Mem_Br        = exmem_q.mem_br;
   assign bus.Zero          = exmem_q.zero;
   assign bus.write_En      = exmem_q.write_en;
   assign bus.read_En       = exmem_q.read_en;
   assign bus.DataAddress   = exmem_q.data_address;
   assign bus.WriteData     = exmem_q.write_data;
   assign bus.Mem_WB        = exmem_q.mem_wb;
   assign bus.dest          = exmem_q.dest;
   assign bus.branch_target = exmem_q.branch_target;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: drives two ex_stage instances (MUL_STEP_BITS 1 and 4) and checks
// the EX/MEM outputs against a behavioural model of the execute stage.
module tb_ex_stage;
   localparam int unsigned OW = 107;

`ifdef EX_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [2:0]  op;
      logic        alu_src;
      logic        br;
      logic        wr;
      logic        rd;
      logic [1:0]  wb;
      logic [31:0] a;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
      logic        reg_dst;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   ex_stage_if if1 ();
   ex_stage_if if4 ();

   ex_stage #(.MUL_STEP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   ex_stage #(.MUL_STEP_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

   always #5 clk = ~clk;

   wire [OW-1:0] obs1 = {if1.Mem_Br, if1.Zero, if1.write_En, if1.read_En, if1.DataAddress,
                         if1.WriteData, if1.Mem_WB, if1.dest, if1.branch_target};
   wire [OW-1:0] obs4 = {if4.Mem_Br, if4.Zero, if4.write_En, if4.read_En, if4.DataAddress,
                         if4.WriteData, if4.Mem_WB, if4.dest, if4.branch_target};

   // Expected EX/MEM contents for one accepted instruction
   function automatic logic [OW-1:0] model(input instr_t i);
      logic [31:0] b, r;
      if (!i.valid) return '0;
      b = i.alu_src ? i.imm : i.rt;
      case (i.op)
         3'b000:  r = i.a & b;
         3'b001:  r = i.a | b;
         3'b010:  r = i.a + b;
         3'b110:  r = i.a - b;
         3'b111:  r = ($signed(i.a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011:  r = MUL_ON ? i.a * b : 32'd0;
         default: r = 32'd0;
      endcase
      return {i.br, (r == 32'd0), i.wr, i.rd, r, i.rt, i.wb,
              (i.reg_dst ? i.rd_addr : i.rt_addr), i.pc4 + (i.imm << 2)};
   endfunction

   function automatic instr_t rand_instr(input bit allow_mul);
      instr_t i;
      i.valid   = ($urandom_range(0, 7) != 0);
      i.op      = 3'($urandom_range(0, 7));
      if (!allow_mul && i.op == 3'b011) i.op = 3'b010;
      i.alu_src = 1'($urandom);
      i.br      = 1'($urandom);
      i.wr      = 1'($urandom);
      i.rd      = 1'($urandom);
      i.wb      = 2'($urandom);
      i.a       = $urandom;
      i.rt      = $urandom;
      i.imm     = $urandom;
      i.pc4     = $urandom;
      i.rt_addr = 5'($urandom);
      i.rd_addr = 5'($urandom);
      i.reg_dst = 1'($urandom);
      case ($urandom_range(0, 4))
         0: begin i.rt = i.a; i.alu_src = 1'b0; end
         1: i.imm = i.a;
         2: i.a = 32'd0;
         3: begin i.a = 32'h8000_0000; i.rt = 32'h7FFF_FFFF; end
         default: ;
      endcase
      return i;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input instr_t i1, input logic f1, input instr_t i4, input logic f4);
      if1.flush = f1;         if4.flush = f4;
      if1.ex_valid = i1.valid; if4.ex_valid = i4.valid;
      if1.ex_alu_op = i1.op;   if4.ex_alu_op = i4.op;
      if1.ex_alu_src = i1.alu_src; if4.ex_alu_src = i4.alu_src;
      if1.ex_mem_br = i1.br;   if4.ex_mem_br = i4.br;
      if1.ex_mem_write = i1.wr; if4.ex_mem_write = i4.wr;
      if1.ex_mem_read = i1.rd; if4.ex_mem_read = i4.rd;
      if1.ex_wb = i1.wb;       if4.ex_wb = i4.wb;
      if1.rs_data = i1.a;      if4.rs_data = i4.a;
      if1.rt_data = i1.rt;     if4.rt_data = i4.rt;
      if1.imm = i1.imm;        if4.imm = i4.imm;
      if1.pc_plus4 = i1.pc4;   if4.pc_plus4 = i4.pc4;
      if1.rt_addr = i1.rt_addr; if4.rt_addr = i4.rt_addr;
      if1.rd_addr = i1.rd_addr; if4.rd_addr = i4.rd_addr;
      if1.reg_dst = i1.reg_dst; if4.reg_dst = i4.reg_dst;
   endtask

   task automatic test_reset;
      instr_t idle;
      idle = '0;
      rst = 1'b1;
      apply(rand_instr(1'b1), 1'b0, rand_instr(1'b1), 1'b0);
      step;
      apply(rand_instr(1'b1), 1'b0, rand_instr(1'b1), 1'b0);
      step;
      n_checks++; if (obs1 !== '0) begin n_fail++; $display("FAIL reset_out1: got %h want 0", obs1); end
      n_checks++; if (obs4 !== '0) begin n_fail++; $display("FAIL reset_out4: got %h want 0", obs4); end
      n_checks++; if (if1.ex_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", if1.ex_busy); end
      rst = 1'b0;
      apply(idle, 1'b0, idle, 1'b0);
      step;
      n_checks++; if (obs1 !== '0) begin n_fail++; $display("FAIL idle_out1: got %h want 0", obs1); end
      n_checks++; if (obs4 !== '0) begin n_fail++; $display("FAIL idle_out4: got %h want 0", obs4); end
      n_checks++; if (if4.ex_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy4: got %b want 0", if4.ex_busy); end
   endtask

   task automatic test_directed;
      instr_t i;
      // ADD overflow wraps
      i = '0; i.valid = 1'b1; i.op = 3'b010; i.a = 32'h7FFF_FFFF; i.imm = 32'd1;
      i.alu_src = 1'b1; i.rt_addr = 5'd5; i.rd_addr = 5'd9;
      apply(i, 1'b0, i, 1'b0); step;
      n_checks++; if (if1.DataAddress !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", if1.DataAddress); end
      n_checks++; if (if1.Zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", if1.Zero); end
      n_checks++; if (if1.dest !== 5'd5) begin n_fail++; $display("FAIL add_dest: got %0d want 5", if1.dest); end
      n_checks++; if (obs4 !== model(i)) begin n_fail++; $display("FAIL add_model4: got %h want %h", obs4, model(i)); end
      // SUB to zero with a backward branch target
      i = '0; i.valid = 1'b1; i.op = 3'b110; i.a = 32'h1234; i.rt = 32'h1234; i.br = 1'b1;
      i.pc4 = 32'h100; i.imm = 32'hFFFF_FFFF;
      apply(i, 1'b0, i, 1'b0); step;
      n_checks++; if (if1.Mem_Br !== 1'b1) begin n_fail++; $display("FAIL sub_br: got %b want 1", if1.Mem_Br); end
      n_checks++; if (if1.Zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b want 1", if1.Zero); end
      n_checks++; if (if1.branch_target !== 32'hFC) begin n_fail++; $display("FAIL sub_target: got %h want fc", if1.branch_target); end
      // SLT signed, then store back to back
      i = '0; i.valid = 1'b1; i.op = 3'b111; i.a = 32'hFFFF_FFFF; i.rt = 32'd1;
      apply(i, 1'b0, i, 1'b0); step;
      n_checks++; if (if1.DataAddress !== 32'd1) begin n_fail++; $display("FAIL slt_result: got %h want 1", if1.DataAddress); end
      i = '0; i.valid = 1'b1; i.op = 3'b010; i.a = 32'h40; i.imm = 32'd8; i.alu_src = 1'b1;
      i.rt = 32'hDEAD_BEEF; i.wr = 1'b1;
      apply(i, 1'b0, i, 1'b0); step;
      n_checks++; if (if1.write_En !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", if1.write_En); end
      n_checks++; if (if1.DataAddress !== 32'h48) begin n_fail++; $display("FAIL sw_addr: got %h want 48", if1.DataAddress); end
      n_checks++; if (if1.WriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_data: got %h want deadbeef", if1.WriteData); end
      i = '0;
      apply(i, 1'b0, i, 1'b0); step;
   endtask

   task automatic test_random_alu(input int n);
      instr_t i1, i4;
      logic f1, f4;
      logic [OW-1:0] e1, e4;
      for (int k = 0; k < n; k++) begin
         i1 = rand_instr(!MUL_ON); i4 = rand_instr(!MUL_ON);
         f1 = ($urandom_range(0, 7) == 0); f4 = ($urandom_range(0, 7) == 0);
         e1 = f1 ? '0 : model(i1); e4 = f4 ? '0 : model(i4);
         apply(i1, f1, i4, f4); step;
         n_checks++; if (obs1 !== e1) begin n_fail++; $display("FAIL rand1 #%0d op %0d: got %h want %h", k, i1.op, obs1, e1); end
         n_checks++; if (obs4 !== e4) begin n_fail++; $display("FAIL rand4 #%0d op %0d: got %h want %h", k, i4.op, obs4, e4); end
         n_checks++; if ({if1.ex_busy, if4.ex_busy} !== 2'b00) begin n_fail++; $display("FAIL rand_busy #%0d: got %b want 00", k, {if1.ex_busy, if4.ex_busy}); end
      end
   endtask

   // A following single-cycle instruction completes in one edge
   task automatic check_next_accepted(input int which);
      instr_t nxt, idle;
      logic [OW-1:0] o;
      idle = '0;
      nxt = rand_instr(1'b0); nxt.valid = 1'b1;
      if (which == 1) apply(nxt, 1'b0, idle, 1'b0); else apply(idle, 1'b0, nxt, 1'b0);
      step;
      o = (which == 1) ? obs1 : obs4;
      n_checks++; if (o !== model(nxt)) begin n_fail++; $display("FAIL after_mul dut%0d: got %h want %h", which, o, model(nxt)); end
      apply(idle, 1'b0, idle, 1'b0);
   endtask

`ifdef EX_MUL_EN
   task automatic run_mul(input int which, input instr_t m, input int n_exp);
      instr_t idle, junk;
      logic [OW-1:0] exp_o, o;
      logic bz;
      int busy_cycles;
      bit done;
      idle = '0; exp_o = model(m); busy_cycles = 0; done = 1'b0;
      if (which == 1) apply(m, 1'b0, idle, 1'b0); else apply(idle, 1'b0, m, 1'b0);
      for (int c = 0; c < 64 && !done; c++) begin
         step;
         o  = (which == 1) ? obs1 : obs4;
         bz = (which == 1) ? if1.ex_busy : if4.ex_busy;
         if (bz) begin
            busy_cycles++;
            n_checks++; if (o !== '0) begin n_fail++; $display("FAIL mul_bubble dut%0d cyc %0d: got %h want 0", which, c, o); end
            junk = rand_instr(1'b1); junk.valid = 1'b1;
            if (which == 1) apply(junk, 1'b0, idle, 1'b0); else apply(idle, 1'b0, junk, 1'b0);
         end else begin
            done = 1'b1;
            n_checks++; if (o !== exp_o) begin n_fail++; $display("FAIL mul_result dut%0d: got %h want %h", which, o, exp_o); end
            n_checks++; if (busy_cycles != n_exp) begin n_fail++; $display("FAIL mul_busy_len dut%0d: got %0d want %0d", which, busy_cycles, n_exp); end
         end
      end
      if (!done) begin n_checks++; n_fail++; $display("FAIL mul_timeout dut%0d: busy still 1 want 0", which); end
      check_next_accepted(which);
   endtask

   task automatic test_mul;
      instr_t m;
      m = '0; m.valid = 1'b1; m.op = 3'b011; m.a = 32'h0000_FFFF; m.rt = 32'h0001_0001;
      m.wb = 2'b11; m.rt_addr = 5'd3; m.rd_addr = 5'd7; m.reg_dst = 1'b1;
      run_mul(1, m, 32);
      run_mul(4, m, 8);
      for (int k = 0; k < 4; k++) begin
         m = rand_instr(1'b1); m.valid = 1'b1; m.op = 3'b011;
         if (k == 0) m.a = 32'd0;
         run_mul(1, m, 32);
         m = rand_instr(1'b1); m.valid = 1'b1; m.op = 3'b011;
         run_mul(4, m, 8);
      end
   endtask

   task automatic test_mul_flush(input int which, input int cycles_in);
      instr_t m, idle;
      logic [OW-1:0] o;
      logic bz;
      idle = '0;
      m = rand_instr(1'b1); m.valid = 1'b1; m.op = 3'b011; m.a = 32'd3; m.rt = 32'd5; m.alu_src = 1'b0;
      if (which == 1) apply(m, 1'b0, idle, 1'b0); else apply(idle, 1'b0, m, 1'b0);
      step;
      apply(idle, 1'b0, idle, 1'b0);
      for (int k = 1; k < cycles_in; k++) step;
      apply(idle, (which == 1), idle, (which == 4));
      step;
      o  = (which == 1) ? obs1 : obs4;
      bz = (which == 1) ? if1.ex_busy : if4.ex_busy;
      n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL flush_busy dut%0d: got %b want 0", which, bz); end
      n_checks++; if (o !== '0) begin n_fail++; $display("FAIL flush_out dut%0d: got %h want 0", which, o); end
      apply(idle, 1'b0, idle, 1'b0);
      for (int k = 0; k < 36; k++) begin
         step;
         o  = (which == 1) ? obs1 : obs4;
         bz = (which == 1) ? if1.ex_busy : if4.ex_busy;
         n_checks++; if ({bz, o} !== '0) begin n_fail++; $display("FAIL flush_quiet dut%0d cyc %0d: busy %b out %h want 0", which, k, bz, o); end
      end
      check_next_accepted(which);
   endtask

   task automatic test_reset_abort;
      instr_t m, idle;
      idle = '0;
      m = '0; m.valid = 1'b1; m.op = 3'b011; m.a = 32'd7; m.rt = 32'd9;
      apply(m, 1'b0, idle, 1'b0); step;
      apply(idle, 1'b0, idle, 1'b0); step; step;
      rst = 1'b1; step; rst = 1'b0;
      n_checks++; if (if1.ex_busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_busy: got %b want 0", if1.ex_busy); end
      for (int k = 0; k < 34; k++) begin
         step;
         n_checks++; if ({if1.ex_busy, obs1} !== '0) begin n_fail++; $display("FAIL rst_abort_quiet cyc %0d: busy %b out %h want 0", k, if1.ex_busy, obs1); end
      end
   endtask
`else
   task automatic test_mul_disabled;
      instr_t m;
      for (int k = 0; k < 4; k++) begin
         m = rand_instr(1'b1); m.valid = 1'b1; m.op = 3'b011;
         if (k == 0) begin m.a = 32'h0000_FFFF; m.rt = 32'h0001_0001; m.alu_src = 1'b0; end
         apply(m, 1'b0, m, 1'b0); step;
         n_checks++; if (obs1 !== model(m)) begin n_fail++; $display("FAIL mul_off1 #%0d: got %h want %h", k, obs1, model(m)); end
         n_checks++; if (if1.Zero !== 1'b1) begin n_fail++; $display("FAIL mul_off_zero #%0d: got %b want 1", k, if1.Zero); end
         n_checks++; if ({if1.ex_busy, if4.ex_busy} !== 2'b00) begin n_fail++; $display("FAIL mul_off_busy #%0d: got %b want 00", k, {if1.ex_busy, if4.ex_busy}); end
      end
      check_next_accepted(1);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      apply('0, 1'b0, '0, 1'b0);
      test_reset;
      test_directed;
      test_random_alu(300);
`ifdef EX_MUL_EN
      test_mul;
      test_mul_flush(1, 5);
      test_mul_flush(4, 5);
      test_reset_abort;
      test_random_alu(50);
`else
      test_mul_disabled;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
